// File: rtl/muldiv_issue_ctrl_if.sv
// Purpose: EX-stage handshake bundle between the pipeline and the mul/div issue controller.
// Latency: none, signal container only.
// Backpressure: the controller answers a held EX instruction with stall_fde/em_bubble.
interface muldiv_issue_ctrl_if;
    // EX-stage request side
    logic        E_md_valid;
    logic [1:0]  E_md_op;
    logic [31:0] E_b;
    logic        flush;

    // Controller response side
    logic        md_start;
    logic        md_sign;
    logic        md_is_div;
    logic        stall_fde;
    logic        em_bubble;
    logic        hilo_we;
    logic        div_by_zero;
    logic        busy;

    // Pipeline view: presents the instruction, consumes stall/write-back controls
    modport master (
        output E_md_valid, E_md_op, E_b, flush,
        input  md_start, md_sign, md_is_div, stall_fde, em_bubble,
               hilo_we, div_by_zero, busy
    );

    // Controller view
    modport slave (
        input  E_md_valid, E_md_op, E_b, flush,
        output md_start, md_sign, md_is_div, stall_fde, em_bubble,
               hilo_we, div_by_zero, busy
    );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// Purpose: issue/sequence MULT/MULTU/DIV/DIVU on the iterative EX-stage mul/div unit.
// Latency: md_start same cycle as issue; hilo_we exactly MUL_LAT or DIV_LAT cycles later.
// Backpressure: stall_fde/em_bubble held for the full latency; flush or reset abort silently.
module muldiv_issue_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_issue_ctrl_if.slave md_if
);

    // Counter reload values; the issue cycle itself counts as the first of LAT cycles.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_sign;
    logic             r_is_div;
    logic             r_dz;

    logic             w_issue;
    logic             w_busy_st;
    logic             w_done_st;
    logic             w_hilo_we;
    logic             w_b_zero;

    // Issue is gated by reset so nothing launches while reset is being held.
    assign w_issue   = rst && (r_state == S_IDLE) && md_if.E_md_valid && !md_if.flush;
    assign w_busy_st = (r_state == S_BUSY);
    assign w_done_st = (r_state == S_DONE);
    assign w_b_zero  = (md_if.E_b == 32'd0);

    // A flush or reset landing on the DONE cycle kills the write-back.
    assign w_hilo_we = rst && w_done_st && !md_if.flush;

    // Next-state and counter: count down to 1, then spend one cycle in DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = md_if.E_md_op[1] ? DIV_LOAD : MUL_LOAD;
                end
            end
            S_BUSY: begin
                if (md_if.flush) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                // The valid still seen here is the completing instruction; never re-issue.
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State register plus operation attributes captured at issue and held until the next issue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_issue) begin
                r_sign   <= ~md_if.E_md_op[0];
                r_is_div <= md_if.E_md_op[1];
                r_dz     <= md_if.E_md_op[1] && w_b_zero;
            end
        end
    end

    // Front end freezes from the issue cycle through the last BUSY cycle; DONE lets it advance.
    assign md_if.md_start    = w_issue;
    assign md_if.md_sign     = r_sign;
    assign md_if.md_is_div   = r_is_div;
    assign md_if.stall_fde   = w_issue || w_busy_st;
    assign md_if.em_bubble   = w_issue || w_busy_st;
    assign md_if.hilo_we     = w_hilo_we;
    assign md_if.div_by_zero = w_hilo_we && r_dz;
    assign md_if.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Purpose: directed and randomized checking of muldiv_issue_ctrl against a timeline model.
// Latency: model predicts every output each cycle from issue cycle + latency arithmetic.
// Backpressure: checks stall/bubble windows, flush and reset aborts.
module tb_muldiv_issue_ctrl;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    muldiv_issue_ctrl_if ifc ();

    muldiv_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .md_if (ifc)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: an operation is in flight from its issue cycle until cycle issue+LAT (DONE).
    bit m_act = 0, m_sign = 0, m_div = 0, m_dz = 0;
    int m_done_at = 0;
    bit n_act = 0, n_sign = 0, n_div = 0, n_dz = 0;
    int n_done_at = 0;
    logic [7:0] exp_vec;

    // Order: start, sign, is_div, stall, bubble, hilo_we, div_by_zero, busy
    function automatic logic [7:0] obs_vec();
        return {ifc.md_start, ifc.md_sign, ifc.md_is_div, ifc.stall_fde,
                ifc.em_bubble, ifc.hilo_we, ifc.div_by_zero, ifc.busy};
    endfunction

    // Drive one cycle of inputs and compute what the outputs must be in that cycle.
    task automatic apply(input bit v, input bit [1:0] op, input bit [31:0] b,
                         input bit f, input bit r);
        bit issue, st, hw, dzo, bs;
        @(negedge clk);
        cyc++;
        m_act = n_act; m_sign = n_sign; m_div = n_div; m_dz = n_dz; m_done_at = n_done_at;
        ifc.E_md_valid = v;
        ifc.E_md_op    = op;
        ifc.E_b        = b;
        ifc.flush      = f;
        rst            = r;
        #1;
        issue = r && !m_act && v && !f;
        st = 0; hw = 0; dzo = 0; bs = 0;
        if (!m_act) begin
            st = issue;
        end else if (cyc < m_done_at) begin
            st = 1; bs = 1;
        end else begin
            bs = 1; hw = r && !f; dzo = hw && m_dz;
        end
        exp_vec = {issue, m_sign, m_div, st, st, hw, dzo, bs};
        n_act = m_act; n_sign = m_sign; n_div = m_div; n_dz = m_dz; n_done_at = m_done_at;
        if (!r) begin
            n_act = 0; n_sign = 0; n_div = 0; n_dz = 0;
        end else if (issue) begin
            n_act     = 1;
            n_done_at = cyc + (op[1] ? DIV_LAT : MUL_LAT);
            n_sign    = ~op[0];
            n_div     = op[1];
            n_dz      = op[1] && (b == 32'd0);
        end else if (m_act && ((f && cyc < m_done_at) || cyc >= m_done_at)) begin
            n_act = 0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1, 2'b00, 32'd5, 0, 0);
            checks++;
            if (obs_vec() !== 8'h00) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d got %b exp %b", i, obs_vec(), 8'h00);
            end
        end
        apply(1, 2'b00, 32'd5, 0, 1);
        checks++;
        if (ifc.md_start !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_issue got %b exp 1", ifc.md_start);
        end
        for (int k = 1; k < 6; k++) begin
            apply(0, 2'b00, 32'd0, 0, 1);
            checks++;
            if (obs_vec() !== exp_vec) begin
                errors++;
                $display("FAIL reset_drain off %0d got %b exp %b", k, obs_vec(), exp_vec);
            end
        end
    endtask

    task automatic test_mult();
        int stalls = 0;
        for (int k = 0; k < 6; k++) begin
            apply(k <= MUL_LAT, 2'b00, 32'd9, 0, 1);
            checks++;
            if (obs_vec() !== exp_vec) begin
                errors++;
                $display("FAIL mult_vec off %0d got %b exp %b", k, obs_vec(), exp_vec);
            end
            checks++;
            if (ifc.hilo_we !== (k == MUL_LAT)) begin
                errors++;
                $display("FAIL mult_hilo off %0d got %b exp %b", k, ifc.hilo_we, k == MUL_LAT);
            end
            if (k >= 1) begin
                checks++;
                if (ifc.md_sign !== 1'b1 || ifc.md_is_div !== 1'b0) begin
                    errors++;
                    $display("FAIL mult_flags off %0d got %b%b exp 10", k, ifc.md_sign, ifc.md_is_div);
                end
            end
            if (ifc.stall_fde === 1'b1) stalls++;
        end
        checks++;
        if (stalls != MUL_LAT) begin
            errors++;
            $display("FAIL mult_stall_len got %0d exp %0d", stalls, MUL_LAT);
        end
    endtask

    task automatic test_divu_zero();
        int stalls = 0;
        for (int k = 0; k < DIV_LAT + 2; k++) begin
            apply(k <= DIV_LAT, 2'b11, 32'd0, 0, 1);
            checks++;
            if (obs_vec() !== exp_vec) begin
                errors++;
                $display("FAIL divz_vec off %0d got %b exp %b", k, obs_vec(), exp_vec);
            end
            if (ifc.stall_fde === 1'b1) stalls++;
            if (k == DIV_LAT) begin
                checks++;
                if ({ifc.hilo_we, ifc.div_by_zero, ifc.md_sign, ifc.md_is_div} !== 4'b1101) begin
                    errors++;
                    $display("FAIL divz_done got %b exp 1101",
                             {ifc.hilo_we, ifc.div_by_zero, ifc.md_sign, ifc.md_is_div});
                end
            end
        end
        checks++;
        if (stalls != DIV_LAT) begin
            errors++;
            $display("FAIL divz_stall_len got %0d exp %0d", stalls, DIV_LAT);
        end
    endtask

    task automatic test_back_to_back();
        int hilos = 0;
        for (int k = 0; k < MUL_LAT + DIV_LAT + 3; k++) begin
            if (k <= MUL_LAT) apply(1, 2'b01, 32'd3, 0, 1);
            else              apply(k == MUL_LAT + 1, 2'b10, 32'd7, 0, 1);
            checks++;
            if (obs_vec() !== exp_vec) begin
                errors++;
                $display("FAIL b2b_vec off %0d got %b exp %b", k, obs_vec(), exp_vec);
            end
            checks++;
            if (ifc.md_start !== (k == 0 || k == MUL_LAT + 1)) begin
                errors++;
                $display("FAIL b2b_start off %0d got %b exp %b", k, ifc.md_start,
                         (k == 0 || k == MUL_LAT + 1));
            end
            if (ifc.hilo_we === 1'b1) hilos++;
        end
        checks++;
        if (hilos != 2) begin
            errors++;
            $display("FAIL b2b_hilo_count got %0d exp 2", hilos);
        end
    endtask

    task automatic test_flush();
        int hilos = 0;
        for (int k = 0; k < DIV_LAT + 4; k++) begin
            apply(k == 0, 2'b10, 32'd3, k == 2, 1);
            checks++;
            if (obs_vec() !== exp_vec) begin
                errors++;
                $display("FAIL flush_vec off %0d got %b exp %b", k, obs_vec(), exp_vec);
            end
            if (k == 3) begin
                checks++;
                if ({ifc.stall_fde, ifc.busy} !== 2'b00) begin
                    errors++;
                    $display("FAIL flush_idle got %b exp 00", {ifc.stall_fde, ifc.busy});
                end
            end
            if (ifc.hilo_we === 1'b1) hilos++;
        end
        checks++;
        if (hilos != 0) begin
            errors++;
            $display("FAIL flush_no_hilo got %0d exp 0", hilos);
        end
        // Flush while idle must block issue entirely.
        apply(1, 2'b00, 32'd1, 1, 1);
        checks++;
        if ({ifc.md_start, ifc.stall_fde} !== 2'b00) begin
            errors++;
            $display("FAIL flush_idle_block got %b exp 00", {ifc.md_start, ifc.stall_fde});
        end
    endtask

    task automatic test_reset_mid();
        int hilos = 0;
        for (int k = 0; k < 18; k++) begin
            if (k < 10)       apply(k == 0, 2'b10, 32'd4, 0, 1);
            else if (k == 10) apply(0, 2'b10, 32'd4, 0, 0);
            else              apply(k == 11, 2'b00, 32'd4, 0, 1);
            checks++;
            if (obs_vec() !== exp_vec) begin
                errors++;
                $display("FAIL rstmid_vec off %0d got %b exp %b", k, obs_vec(), exp_vec);
            end
            if (ifc.hilo_we === 1'b1) begin
                hilos++;
                checks++;
                if (k != 11 + MUL_LAT) begin
                    errors++;
                    $display("FAIL rstmid_hilo_time got %0d exp %0d", k, 11 + MUL_LAT);
                end
            end
        end
        checks++;
        if (hilos != 1) begin
            errors++;
            $display("FAIL rstmid_hilo_count got %0d exp 1", hilos);
        end
    endtask

    task automatic test_random();
        bit v, f, r;
        bit [1:0] op;
        bit [31:0] b;
        for (int k = 0; k < 1500; k++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = 2'($urandom_range(0, 3));
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            f  = ($urandom_range(0, 24) == 0);
            r  = ($urandom_range(0, 199) != 0);
            apply(v, op, b, f, r);
            checks++;
            if (obs_vec() !== exp_vec) begin
                errors++;
                $display("FAIL random_vec cyc %0d got %b exp %b", cyc, obs_vec(), exp_vec);
            end
        end
    endtask

    initial begin
        ifc.E_md_valid = 0;
        ifc.E_md_op    = 2'b00;
        ifc.E_b        = 32'd0;
        ifc.flush      = 0;
        rst            = 0;
        @(posedge clk);
        test_reset();
        test_mult();
        test_divu_zero();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- Sequencing controller for the multi-cycle multiply/divide resource in the EX stage of the dynamic pipeline CPU.
- Detects MULT/MULTU/DIV/DIVU in EX and launches the iterative unit.
- Holds the instruction in EX for a fixed latency, freezing the front end and feeding bubbles into the EX/MEM register.
- Issues a one-cycle HI/LO write enable when results are ready.

Parameters:
- MUL_LAT, default 4: total cycles from issue to DONE for multiply. Must be ≥2.
- DIV_LAT, default 33: total cycles from issue to DONE for divide. Must be ≥2.
- CNT_W, default 6: cycle counter width. Must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low
- E_md_valid  in  1  EX holds a valid mul/div instruction
- E_md_op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- E_b  in  32  divisor operand, used for divide-by-zero detect only
- flush  in  1  EX-stage kill from exception or redirect
- md_start  out  1  one-cycle launch pulse to the mul/div unit
- md_sign  out  1  latched signed flag: 1 for MULT/DIV
- md_is_div  out  1  latched divide flag
- stall_fde  out  1  freeze PC, IF/ID and ID/EX registers
- em_bubble  out  1  force EX/MEM control fields (w_rf, w_dm, w_hi, w_lo) to 0
- hilo_we  out  1  write HI and LO this cycle
- div_by_zero  out  1  valid with hilo_we: divide issued with E_b==0
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst==0 at a rising edge): state=IDLE, cnt=0, md_sign=0, md_is_div=0, dz_reg=0. All outputs 0. Reset overrides everything, including mid-operation; no hilo_we is produced for an aborted operation.
- Three states: IDLE, BUSY, DONE.
- issue = (state==IDLE) && E_md_valid && !flush.
- IDLE:
  - If issue: md_start=1 (combinational, same cycle).
  - At the edge: latch md_sign=~E_md_op[0] and md_is_div=E_md_op[1]; latch dz_reg=E_md_op[1] && (E_b==0); load cnt=LAT-1 (LAT selected by E_md_op[1]); go to BUSY.
  - Otherwise remain in IDLE.
- BUSY:
  - If flush: go to IDLE, cnt=0, no hilo_we.
  - Else if cnt==1: go to DONE.
  - Else: cnt=cnt-1.
  - E_md_valid is ignored.
- DONE:
  - hilo_we=1; div_by_zero=dz_reg.
  - Next state is IDLE unconditionally. E_md_valid seen in DONE belongs to the completing instruction and must not re-issue.
  - flush in DONE suppresses hilo_we and still returns to IDLE.
- stall_fde = issue || (state==BUSY). em_bubble = stall_fde.
- Timing, issue in cycle 0: stall_fde high in cycles 0..LAT-1 (exactly LAT cycles); DONE and hilo_we in cycle LAT; stall_fde low in cycle LAT, so the instruction advances to MEM at the end of cycle LAT. Earliest next issue is cycle LAT+1.
- md_start never asserts outside IDLE. There is at most one operation in flight.
- flush in IDLE blocks issue: no md_start, no stall.
- Divide by zero: full DIV_LAT latency, hilo_we still asserted, div_by_zero=1 in DONE. Multiply never sets div_by_zero.
- md_sign and md_is_div hold their values from issue until the next issue; they are not cleared on DONE.
- busy = (state != IDLE).
- Counter arithmetic: unsigned, CNT_W bits. It never underflows, because the decrement occurs only when cnt>1.

Test Plan:
- Reset: rst=0 for 2 cycles with E_md_valid=1 → all outputs 0, busy=0. Release rst → issue occurs on the next cycle.
- MULT (op=00), MUL_LAT=4, issue at cycle 0 → md_start=1 only at cycle 0, md_sign=1, md_is_div=0; stall_fde/em_bubble high cycles 0–3; hilo_we=1 only at cycle 4; busy low at cycle 5.
- DIVU (op=11), E_b=0, DIV_LAT=33 → stall_fde high for 33 cycles; cycle 33: hilo_we=1, div_by_zero=1, md_sign=0, md_is_div=1.
- Back-to-back: MULTU, then DIV presented in the cycle after DONE → second md_start exactly at cycle MUL_LAT+1; no md_start during DONE even though E_md_valid=1.
- Flush at BUSY cycle 2 of a DIV → returns to IDLE next cycle; no hilo_we ever; stall_fde low from the cycle after flush.
- Reset mid-operation: rst=0 at cycle 10 of a DIV → IDLE at the next edge; hilo_we never asserted; new MULT issues normally afterward with MUL_LAT latency.
